// File: rtl/uart_pkg.sv
// Definitions shared by the UART transmitter and receiver.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_state_e;

  localparam int unsigned DEF_CLKS_PER_BIT = 434;
  localparam int unsigned DEF_DATA_BITS    = 8;

endpackage

// File: rtl/uart_tx.sv
// UART transmitter: 1 start bit, DATA_BITS data bits LSB first, 1 or 2 stop bits.
// Byte and stop-bit select are captured when a request is accepted in IDLE.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int unsigned DATA_BITS    = DEF_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 snum,
  input  logic [DATA_BITS-1:0] d_tx,
  input  logic                 tx_start,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int unsigned BaudW = $clog2(CLKS_PER_BIT);
  localparam int unsigned BitW  = (DATA_BITS > 2) ? $clog2(DATA_BITS) : 1;

  localparam logic [BaudW-1:0] BaudLast = BaudW'(CLKS_PER_BIT - 1);
  localparam logic [BitW-1:0]  DataLast = BitW'(DATA_BITS - 1);

  uart_state_e          state_q, state_d;
  logic [BaudW-1:0]     baud_q, baud_d;
  logic [BitW-1:0]      bit_q, bit_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 snum_q, snum_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 baud_end;

  assign baud_end = (baud_q == BaudLast);

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    snum_d  = snum_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    if (state_q != IDLE) begin
      baud_d = baud_end ? '0 : baud_q + BaudW'(1);
    end

    unique case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (tx_start) begin
          shreg_d = d_tx;
          snum_d  = snum;
          baud_d  = '0;
          bit_d   = '0;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
          state_d = START;
        end
      end
      START: begin
        if (baud_end) begin
          bit_d   = '0;
          tx_d    = shreg_q[0];
          state_d = DATA;
        end
      end
      DATA: begin
        if (baud_end) begin
          if (bit_q == DataLast) begin
            bit_d   = '0;
            tx_d    = 1'b1;
            state_d = STOP;
          end else begin
            shreg_d = shreg_q >> 1;
            bit_d   = bit_q + BitW'(1);
            tx_d    = shreg_d[0];
          end
        end
      end
      STOP: begin
        // bit_q counts stop bits already sent; the latched snum is the last index.
        if (baud_end) begin
          if (bit_q == BitW'(snum_q)) begin
            tx_d    = 1'b1;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            bit_d = bit_q + BitW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      snum_q  <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      snum_q  <= snum_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign tx      = tx_q;
  assign tx_busy = busy_q;
  assign tx_done = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx with two clocks per bit; a frame's line levels are
// captured per cycle and compared against hand-written bit sequences.
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       reset;
  logic       snum;
  logic [7:0] d_tx;
  logic       tx_start;
  logic       tx;
  logic       tx_busy;
  logic       tx_done;

  int n_checks = 0;
  int n_pass   = 0;

  logic cap_tx   [0:63];
  logic cap_busy [0:63];
  logic cap_done [0:63];

  uart_tx #(
    .CLKS_PER_BIT(2),
    .DATA_BITS   (8)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .snum    (snum),
    .d_tx    (d_tx),
    .tx_start(tx_start),
    .tx      (tx),
    .tx_busy (tx_busy),
    .tx_done (tx_done)
  );

  always #10 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic capture(input int first, input int n);
    for (int c = first; c < first + n; c++) begin
      cap_tx[c]   = tx;
      cap_busy[c] = tx_busy;
      cap_done[c] = tx_done;
      step();
    end
  endtask

  task automatic start_frame(input logic [7:0] data, input logic stop2);
    d_tx     = data;
    snum     = stop2;
    tx_start = 1'b1;
    step();
    tx_start = 1'b0;
  endtask

  function automatic logic [1:0] bit_at(input int c);
    return {cap_tx[c], cap_tx[c+1]};
  endfunction

  function automatic int count_done(input int first, input int n);
    int k = 0;
    for (int c = first; c < first + n; c++) if (cap_done[c] === 1'b1) k++;
    return k;
  endfunction

  function automatic int count_busy(input int first, input int n);
    int k = 0;
    for (int c = first; c < first + n; c++) if (cap_busy[c] === 1'b1) k++;
    return k;
  endfunction

  // Receiver model: second cycle of each data bit, LSB first.
  function automatic logic [7:0] decode(input int first);
    logic [7:0] r;
    for (int b = 0; b < 8; b++) r[b] = cap_tx[first + 2 * (b + 1) + 1];
    return r;
  endfunction

  task automatic test_reset();
    logic [2:0] got;
    int bad = 0;
    reset = 1'b1;
    repeat (3) step();
    got = {tx, tx_busy, tx_done};
    n_checks++;
    if (got !== 3'b100) $display("FAIL reset_hold: got %b want 100", got);
    else n_pass++;
    reset = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if ({tx, tx_busy, tx_done} !== 3'b100) bad++;
      step();
    end
    n_checks++;
    if (bad != 0) $display("FAIL reset_idle: got %0d bad cycles want 0", bad);
    else n_pass++;
  endtask

  task automatic test_single_frame();
    logic [0:9] exp_seq;
    exp_seq = 10'b0101001011;
    start_frame(8'hA5, 1'b0);
    capture(0, 24);
    for (int b = 0; b < 10; b++) begin
      n_checks++;
      if (bit_at(2 * b) !== {2{exp_seq[b]}})
        $display("FAIL a5_bit%0d: got %b want %b", b, bit_at(2 * b), {2{exp_seq[b]}});
      else n_pass++;
    end
    n_checks++;
    if (count_busy(0, 24) != 20 || cap_busy[0] !== 1'b1)
      $display("FAIL a5_busy: got %0d busy cycles want 20", count_busy(0, 24));
    else n_pass++;
    n_checks++;
    if (count_done(0, 24) != 1 || cap_done[20] !== 1'b1)
      $display("FAIL a5_done: got count %0d at20 %b want 1 at cycle 20",
               count_done(0, 24), cap_done[20]);
    else n_pass++;
  endtask

  task automatic test_two_stop();
    logic [0:10] exp_seq;
    exp_seq = 11'b01111000011;
    start_frame(8'h0F, 1'b1);
    capture(0, 26);
    for (int b = 0; b < 11; b++) begin
      n_checks++;
      if (bit_at(2 * b) !== {2{exp_seq[b]}})
        $display("FAIL 0f_bit%0d: got %b want %b", b, bit_at(2 * b), {2{exp_seq[b]}});
      else n_pass++;
    end
    n_checks++;
    if (count_busy(0, 26) != 22)
      $display("FAIL 0f_busy: got %0d busy cycles want 22", count_busy(0, 26));
    else n_pass++;
    n_checks++;
    if (count_done(0, 26) != 1 || cap_done[22] !== 1'b1)
      $display("FAIL 0f_done: got count %0d at22 %b want 1 at cycle 22",
               count_done(0, 26), cap_done[22]);
    else n_pass++;
  endtask

  task automatic test_busy_reject();
    logic [0:9] exp_seq;
    int         bad = 0;
    exp_seq = 10'b0001111001;
    start_frame(8'h3C, 1'b0);
    capture(0, 4);
    d_tx     = 8'hFF;
    snum     = 1'b1;
    tx_start = 1'b1;
    capture(4, 1);
    tx_start = 1'b0;
    capture(5, 21);
    for (int b = 0; b < 10; b++) begin
      n_checks++;
      if (bit_at(2 * b) !== {2{exp_seq[b]}})
        $display("FAIL 3c_bit%0d: got %b want %b", b, bit_at(2 * b), {2{exp_seq[b]}});
      else n_pass++;
    end
    for (int c = 20; c < 26; c++) if (cap_tx[c] !== 1'b1) bad++;
    n_checks++;
    if (bad != 0) $display("FAIL 3c_no_requeue: got %0d low cycles want 0", bad);
    else n_pass++;
    n_checks++;
    if (count_done(0, 26) != 1 || cap_done[20] !== 1'b1)
      $display("FAIL 3c_done: got count %0d want 1 at cycle 20", count_done(0, 26));
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [0:9] exp_a;
    logic [0:9] exp_b;
    exp_a = 10'b0101010101;
    exp_b = 10'b0010101011;
    d_tx     = 8'h55;
    snum     = 1'b0;
    tx_start = 1'b1;
    step();
    d_tx = 8'hAA;
    capture(0, 43);
    tx_start = 1'b0;
    for (int b = 0; b < 10; b++) begin
      n_checks++;
      if (bit_at(2 * b) !== {2{exp_a[b]}} || bit_at(21 + 2 * b) !== {2{exp_b[b]}})
        $display("FAIL b2b_bit%0d: got %b/%b want %b/%b", b, bit_at(2 * b),
                 bit_at(21 + 2 * b), {2{exp_a[b]}}, {2{exp_b[b]}});
      else n_pass++;
    end
    n_checks++;
    if (cap_done[20] !== 1'b1 || cap_done[41] !== 1'b1 || count_done(0, 43) != 2)
      $display("FAIL b2b_done: got %b/%b count %0d want 1/1 count 2",
               cap_done[20], cap_done[41], count_done(0, 43));
    else n_pass++;
    // Held request restarts a third frame right after the second tx_done.
    n_checks++;
    if (cap_tx[42] !== 1'b0) $display("FAIL b2b_restart: got %b want 0", cap_tx[42]);
    else n_pass++;
    repeat (30) step();
    n_checks++;
    if (tx_busy !== 1'b0) $display("FAIL b2b_drain: got busy %b want 0", tx_busy);
    else n_pass++;
  endtask

  task automatic test_loopback_reset();
    logic [2:0] got;
    int         bad = 0;
    start_frame(8'hC3, 1'b0);
    capture(0, 22);
    n_checks++;
    if (decode(0) !== 8'hC3 || cap_tx[1] !== 1'b0 || cap_tx[19] !== 1'b1)
      $display("FAIL loop_c3: got %h want c3", decode(0));
    else n_pass++;

    start_frame(8'h96, 1'b0);
    capture(0, 6);
    reset = 1'b1;
    step();
    got = {tx, tx_busy, tx_done};
    n_checks++;
    if (got !== 3'b100) $display("FAIL midreset_now: got %b want 100", got);
    else n_pass++;
    reset = 1'b0;
    capture(0, 30);
    for (int c = 0; c < 30; c++) if (cap_tx[c] !== 1'b1) bad++;
    n_checks++;
    if (bad != 0 || count_done(0, 30) != 0)
      $display("FAIL midreset_quiet: got %0d low %0d done want 0 0", bad, count_done(0, 30));
    else n_pass++;

    start_frame(8'h5A, 1'b0);
    capture(0, 22);
    n_checks++;
    if (decode(0) !== 8'h5A || count_done(0, 22) != 1 || cap_done[20] !== 1'b1)
      $display("FAIL after_reset_5a: got %h done %0d want 5a done 1",
               decode(0), count_done(0, 22));
    else n_pass++;
  endtask

  initial begin
    reset    = 1'b1;
    snum     = 1'b0;
    d_tx     = 8'h00;
    tx_start = 1'b0;
    test_reset();
    test_single_frame();
    test_two_stop();
    test_busy_reject();
    test_back_to_back();
    test_loopback_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "timeout");
  end

endmodule
